// File: rtl/fetch_unit.sv
// Instruction-fetch stage: next-PC select, PC register, word-addressed
// instruction memory, PC incrementer and the F/D pipeline register.
module fetch_unit #(
    parameter int                   WORD_SIZE  = 32,
    parameter int                   IMEM_DEPTH = 1024,
    parameter logic [WORD_SIZE-1:0] PC_INITIAL = '0,
    parameter string                INIT_FILE  = ""
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 PCSrcE,
    input  logic [WORD_SIZE-1:0] PCTargetE,
    input  logic                 StallF,
    input  logic                 StallD,
    input  logic                 ImemWE,
    input  logic [WORD_SIZE-1:0] ImemWAddr,
    input  logic [WORD_SIZE-1:0] ImemWData,
    output logic [WORD_SIZE-1:0] PCF,
    output logic [WORD_SIZE-1:0] InstrD,
    output logic [WORD_SIZE-1:0] PCD,
    output logic [WORD_SIZE-1:0] PCPlus4D
);

    localparam int AW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
    localparam logic [WORD_SIZE-1:0] DEPTH = WORD_SIZE'(IMEM_DEPTH);

    typedef struct packed {
        logic [WORD_SIZE-1:0] instr;
        logic [WORD_SIZE-1:0] pc;
        logic [WORD_SIZE-1:0] pcPlus4;
    } fdReg_t;

    logic [WORD_SIZE-1:0] mem [IMEM_DEPTH];
    logic [WORD_SIZE-1:0] pcPlus4F;
    logic [WORD_SIZE-1:0] pcNext;
    logic [WORD_SIZE-1:0] instrF;
    logic                 pcInRange;
    logic                 wInRange;
    fdReg_t               fdQ;

    // Unloaded words must read as 0 rather than X.
    initial begin
        for (int i = 0; i < IMEM_DEPTH; i++) begin
            mem[i] = '0;
        end
    end

    assign pcPlus4F  = PCF + {{(WORD_SIZE-1){1'b0}}, 1'b1};
    assign pcNext    = PCSrcE ? PCTargetE : pcPlus4F;
    assign pcInRange = (PCF < DEPTH);
    assign wInRange  = (ImemWAddr < DEPTH);

    always_comb begin
        instrF = '0;
        if (pcInRange) begin
            instrF = mem[PCF[AW-1:0]];
        end
    end

    // Memory ignores rst so programs can be loaded while the core is held.
    always_ff @(posedge clk) begin
        if (ImemWE && wInRange) begin
            mem[ImemWAddr[AW-1:0]] <= ImemWData;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            PCF <= PC_INITIAL;
        end else if (!StallF) begin
            PCF <= pcNext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fdQ.instr   <= '0;
            fdQ.pc      <= PC_INITIAL;
            fdQ.pcPlus4 <= '0;
        end else if (!StallD) begin
            fdQ.instr   <= instrF;
            fdQ.pc      <= PCF;
            fdQ.pcPlus4 <= pcPlus4F;
        end
    end

    assign InstrD   = fdQ.instr;
    assign PCD      = fdQ.pc;
    assign PCPlus4D = fdQ.pcPlus4;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit.
// Each record drives one clock edge and lists the post-edge outputs.
module tb_fetch_unit;

    typedef struct {
        logic        rst;
        logic        srcE;
        logic [31:0] tgt;
        logic        stF;
        logic        stD;
        logic        we;
        logic [31:0] wa;
        logic [31:0] wd;
        logic [31:0] ePCF;
        logic [31:0] eInstr;
        logic [31:0] ePCD;
        logic [31:0] ePlus;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        StallF;
    logic        StallD;
    logic        ImemWE;
    logic [31:0] ImemWAddr;
    logic [31:0] ImemWData;
    logic [31:0] PCF;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;

    int   nRun  = 0;
    int   nFail = 0;
    vec_t vecs[$];

    fetch_unit dut (
        .clk       (clk),
        .rst       (rst),
        .PCSrcE    (PCSrcE),
        .PCTargetE (PCTargetE),
        .StallF    (StallF),
        .StallD    (StallD),
        .ImemWE    (ImemWE),
        .ImemWAddr (ImemWAddr),
        .ImemWData (ImemWData),
        .PCF       (PCF),
        .InstrD    (InstrD),
        .PCD       (PCD),
        .PCPlus4D  (PCPlus4D)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        nRun++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic s, input logic [31:0] t,
                       input logic sf, input logic sd, input logic w,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] p, input logic [31:0] i,
                       input logic [31:0] pd, input logic [31:0] p4);
        vec_t v;
        v.rst = r; v.srcE = s; v.tgt = t; v.stF = sf; v.stD = sd;
        v.we = w; v.wa = a; v.wd = d;
        v.ePCF = p; v.eInstr = i; v.ePCD = pd; v.ePlus = p4;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst; PCSrcE = v.srcE; PCTargetE = v.tgt;
        StallF = v.stF; StallD = v.stD;
        ImemWE = v.we; ImemWAddr = v.wa; ImemWData = v.wd;
    endtask

    task automatic checkAll(input string tag, input logic [31:0] p,
                            input logic [31:0] i, input logic [31:0] pd,
                            input logic [31:0] p4);
        check({tag, ".PCF"}, PCF, p);
        check({tag, ".InstrD"}, InstrD, i);
        check({tag, ".PCD"}, PCD, pd);
        check({tag, ".PCPlus4D"}, PCPlus4D, p4);
    endtask

    initial begin
        // rst srcE tgt stF stD we addr data | PCF InstrD PCD PCPlus4D
        add(1,0,0,0,0, 1,32'h0,32'h11,         0,0,0,0);
        add(1,0,0,0,0, 1,32'h1,32'h22,         0,0,0,0);
        add(1,0,0,0,0, 1,32'h2,32'h33,         0,0,0,0);
        add(1,0,0,0,0, 1,32'h3,32'h44,         0,0,0,0);
        add(1,0,0,0,0, 1,32'h10,32'hAA,        0,0,0,0);
        add(1,1,32'h20,1,1, 1,32'd1023,32'h5,  0,0,0,0);
        // sequential fetch
        add(0,0,0,0,0, 0,0,0,                  1,32'h11,0,1);
        add(0,0,0,0,0, 0,0,0,                  2,32'h22,1,2);
        // redirect
        add(0,1,32'h10,0,0, 0,0,0,             32'h10,32'h33,2,3);
        add(0,0,0,0,0, 0,0,0,                  32'h11,32'hAA,32'h10,32'h11);
        add(0,1,32'h3,0,0, 0,0,0,              3,0,32'h11,32'h12);
        // full stall, then F-only stall reloading mem[3]
        add(0,0,0,1,1, 0,0,0,                  3,0,32'h11,32'h12);
        add(0,0,0,1,1, 0,0,0,                  3,0,32'h11,32'h12);
        add(0,0,0,1,0, 0,0,0,                  3,32'h44,3,4);
        add(0,0,0,1,0, 0,0,0,                  3,32'h44,3,4);
        // stall beats redirect, redirect not remembered
        add(0,1,32'h20,1,0, 0,0,0,             3,32'h44,3,4);
        add(0,0,0,0,0, 1,32'h4,32'h55,         4,32'h44,3,4);
        // out-of-range write must not alias onto mem[0]
        add(0,0,0,0,0, 1,32'd1024,32'hDEAD,    5,32'h55,4,5);
        // PC at all-ones: out-of-range read and wrap
        add(0,1,32'hFFFFFFFF,0,0, 0,0,0,       32'hFFFFFFFF,0,5,6);
        add(0,0,0,0,0, 0,0,0,                  0,0,32'hFFFFFFFF,0);
        add(0,0,0,0,0, 0,0,0,                  1,32'h11,0,1);
        // last word and first out-of-range word
        add(0,1,32'd1023,0,0, 0,0,0,           1023,32'h22,1,2);
        add(0,0,0,0,0, 0,0,0,                  1024,32'h5,1023,1024);
        add(0,0,0,0,0, 0,0,0,                  1025,0,1024,1025);
        // mid-run reset overrides stalls and redirect
        add(0,1,32'h6,0,0, 0,0,0,              6,0,1025,1026);
        add(0,0,0,0,0, 0,0,0,                  7,0,6,7);
        add(1,1,32'h20,1,1, 0,0,0,             0,0,0,0);
        add(0,0,0,0,0, 0,0,0,                  1,32'h11,0,1);
        add(0,0,0,0,0, 0,0,0,                  2,32'h22,1,2);
        // D-only stall: PC advances independently
        add(0,0,0,0,1, 0,0,0,                  3,32'h22,1,2);
        add(0,0,0,0,0, 0,0,0,                  4,32'h44,3,4);

        drive(vecs[0]);
        for (int k = 0; k < vecs.size(); k++) begin
            drive(vecs[k]);
            @(posedge clk);
            #1;
            checkAll($sformatf("vec%0d", k), vecs[k].ePCF, vecs[k].eInstr,
                     vecs[k].ePCD, vecs[k].ePlus);
        end

        // Write the word under a held PC, then let D pick up the new value.
        rst = 0; PCSrcE = 0; PCTargetE = 0;
        StallF = 1; StallD = 1;
        ImemWE = 1; ImemWAddr = 32'h4; ImemWData = 32'h99;
        @(posedge clk);
        #1;
        checkAll("wrHold", 4, 32'h44, 3, 4);
        ImemWE = 0; StallD = 0;
        @(posedge clk);
        #1;
        checkAll("wrRead", 4, 32'h99, 4, 5);
        StallF = 0;
        @(posedge clk);
        #1;
        checkAll("wrResume", 5, 32'h99, 4, 5);

        $display("[TB] %0d tests run, %0d failed", nRun, nFail);
        $finish;
    end

endmodule
